// File: rtl/reaction_time_counter_pkg.sv
// Shared types and constants for the reaction-time counter and its BCD helpers.
package reaction_time_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIGIT_W  = 4;
    localparam int N_DIGITS = 6;
    localparam int BCD_W    = DIGIT_W * N_DIGITS;

    localparam logic [BCD_W-1:0] BCD_MAX = 24'h999999;

endpackage

// File: rtl/reaction_time_counter_bcd_incr6.sv
// Combinational 6-digit packed-BCD increment; o_carry flags an all-nines input.
module bcd_incr6
    import reaction_time_counter_pkg::*;
(
    input  logic [BCD_W-1:0] i_value,
    output logic [BCD_W-1:0] o_value,
    output logic             o_carry
);

    logic [N_DIGITS:0] w_c;

    always_comb begin
        w_c     = '0;
        w_c[0]  = 1'b1;
        o_value = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (w_c[d] && (i_value[d*DIGIT_W +: DIGIT_W] == 4'd9)) begin
                o_value[d*DIGIT_W +: DIGIT_W] = 4'd0;
                w_c[d+1]                      = 1'b1;
            end else if (w_c[d]) begin
                o_value[d*DIGIT_W +: DIGIT_W] = i_value[d*DIGIT_W +: DIGIT_W] + 4'd1;
            end else begin
                o_value[d*DIGIT_W +: DIGIT_W] = i_value[d*DIGIT_W +: DIGIT_W];
            end
        end
        o_carry = w_c[N_DIGITS];
    end

endmodule

// File: rtl/reaction_time_counter.sv
// Reaction timer: ms prescaler, 6-digit BCD time, best-time register with clear.
//  state   | meaning
//  IDLE    | waiting for start, outputs at reset/cleared values
//  RUN     | stimulus lit, counting milliseconds
//  DONE    | result frozen until the next start
module reaction_time_counter
    import reaction_time_counter_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clr_best,
    output logic [BCD_W-1:0] time_bcd,
    output logic [BCD_W-1:0] best_bcd,
    output logic             best_valid,
    output logic             running,
    output logic             done,
    output logic             new_best,
    output logic             overflow
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

    state_t           r_state, w_next;
    logic [PW-1:0]    r_presc;
    logic [BCD_W-1:0] r_time, r_best;
    logic             r_best_valid, r_new_best, r_overflow;

    logic [BCD_W-1:0] w_time_inc;
    logic             w_all_nines, w_tick, w_start_ev, w_stop_ev, w_ovf_ev, w_improve;

    bcd_incr6 u_incr (
        .i_value (r_time),
        .o_value (w_time_inc),
        .o_carry (w_all_nines)
    );

    assign w_tick     = (r_state == ST_RUN) && (r_presc == PRESC_TC);
    assign w_start_ev = start && (r_state != ST_RUN);
    assign w_stop_ev  = stop && (r_state == ST_RUN);
    // stop on the same edge as the saturating tick takes priority
    assign w_ovf_ev   = w_tick && !stop && w_all_nines;
    assign w_improve  = !r_best_valid || (r_time < r_best);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_RUN;
            ST_RUN:           if (stop || w_ovf_ev) w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (r_state == ST_RUN);
        done    = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_time       <= '0;
            r_overflow   <= 1'b0;
            r_best       <= '0;
            r_best_valid <= 1'b0;
            r_new_best   <= 1'b0;
        end else begin
            if (w_start_ev) begin
                r_presc    <= '0;
                r_time     <= '0;
                r_overflow <= 1'b0;
            end else if ((r_state == ST_RUN) && !stop) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick && w_all_nines) r_overflow <= 1'b1;
                else if (w_tick)           r_time     <= w_time_inc;
            end

            if (clr_best) begin
                r_best       <= '0;
                r_best_valid <= 1'b0;
                r_new_best   <= 1'b0;
            end else if (w_stop_ev && w_improve) begin
                r_best       <= r_time;
                r_best_valid <= 1'b1;
                r_new_best   <= 1'b1;
            end else begin
                r_new_best   <= 1'b0;
            end
        end
    end

    assign time_bcd   = r_time;
    assign best_bcd   = r_best;
    assign best_valid = r_best_valid;
    assign new_best   = r_new_best;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_reaction_time_counter.sv
// Bench for reaction_time_counter: run table with result scoreboard plus corner sequences.
module tb_reaction_time_counter;
    import reaction_time_counter_pkg::*;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset, start, stop, clr_best;
    logic [23:0] time_bcd, best_bcd;
    logic        best_valid, running, done, new_best, overflow;

    always #5 clk = ~clk;

    reaction_time_counter #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .clr_best   (clr_best),
        .time_bcd   (time_bcd),
        .best_bcd   (best_bcd),
        .best_valid (best_valid),
        .running    (running),
        .done       (done),
        .new_best   (new_best),
        .overflow   (overflow)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int          cyc;
        logic        clr;
        logic [23:0] e_time;
        logic [23:0] e_best;
        logic        e_valid;
        logic        e_nb;
    } vec_t;

    typedef struct {
        logic [23:0] t;
        logic [23:0] b;
        logic        v;
        logic        nb;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    bit          bad_digit = 1'b0;
    bit          saw_carry = 1'b0;
    logic [23:0] prev_t    = '0;

    always @(negedge clk) begin
        for (int d = 0; d < 6; d++)
            if (time_bcd[d*4 +: 4] > 4'd9) bad_digit = 1'b1;
        if (prev_t == 24'h000999 && time_bcd == 24'h001000) saw_carry = 1'b1;
        prev_t = time_bcd;
    end

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got time %h expected an entry", nm, time_bcd);
        end else begin
            e = exp_q.pop_front();
            chk1({nm, "/done"},     done,       1'b1);
            chk1({nm, "/running"},  running,    1'b0);
            chk ({nm, "/time"},     time_bcd,   e.t);
            chk ({nm, "/best"},     best_bcd,   e.b);
            chk1({nm, "/valid"},    best_valid, e.v);
            chk1({nm, "/new_best"}, new_best,   e.nb);
            chk1({nm, "/overflow"}, overflow,   e.ovf);
        end
    endtask

    task automatic do_vec(input vec_t v);
        start = 1'b1;
        step();
        start = 1'b0;
        chk1({v.name, "/run_started"}, running, 1'b1);
        chk ({v.name, "/time_cleared"}, time_bcd, 24'h0);
        repeat (v.cyc - 1) step();
        stop     = 1'b1;
        clr_best = v.clr;
        exp_q.push_back('{v.e_time, v.e_best, v.e_valid, v.e_nb, 1'b0});
        step();
        stop     = 1'b0;
        clr_best = 1'b0;
        check_done(v.name);
        step();
        chk1({v.name, "/pulse_end"}, new_best, 1'b0);
        chk ({v.name, "/time_hold"}, time_bcd, v.e_time);
    endtask

    initial begin
        // stop at edge start+cyc captures floor((cyc-1)/TD) ticks
        vecs[0] = '{"basic123",     493,  1'b0, 24'h000123, 24'h000123, 1'b1, 1'b1};
        vecs[1] = '{"carry1000",    4001, 1'b0, 24'h001000, 24'h000123, 1'b1, 1'b0};
        vecs[2] = '{"worse200",     801,  1'b0, 24'h000200, 24'h000123, 1'b1, 1'b0};
        vecs[3] = '{"equal123",     493,  1'b0, 24'h000123, 24'h000123, 1'b1, 1'b0};
        vecs[4] = '{"better57",     229,  1'b0, 24'h000057, 24'h000057, 1'b1, 1'b1};
        vecs[5] = '{"stop_on_tick", 40,   1'b0, 24'h000009, 24'h000009, 1'b1, 1'b1};
        vecs[6] = '{"clr_vs_best",  17,   1'b1, 24'h000004, 24'h000000, 1'b0, 1'b0};
        vecs[7] = '{"after_clr",    401,  1'b0, 24'h000100, 24'h000100, 1'b1, 1'b1};

        reset = 1'b1; start = 1'b0; stop = 1'b0; clr_best = 1'b0;
        step();
        step();
        chk ("rst/time",     time_bcd,   24'h0);
        chk ("rst/best",     best_bcd,   24'h0);
        chk1("rst/valid",    best_valid, 1'b0);
        chk1("rst/running",  running,    1'b0);
        chk1("rst/done",     done,       1'b0);
        chk1("rst/new_best", new_best,   1'b0);
        chk1("rst/overflow", overflow,   1'b0);
        reset = 1'b0;

        stop = 1'b1;
        step();
        stop = 1'b0;
        chk1("idle_stop/running", running, 1'b0);
        chk1("idle_stop/done",    done,    1'b0);

        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk1("start_stop/running", running, 1'b1);
        chk1("start_stop/done",    done,    1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) do_vec(vecs[i]);

        chk1("carry/seen_999_to_1000", saw_carry, 1'b1);
        chk1("carry/non_decimal_digit", bad_digit, 1'b0);

        // overflow: preload the counter just below saturation mid-run
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        force dut.r_time = 24'h999998;
        #1;
        release dut.r_time;
        exp_q.push_back('{BCD_MAX, 24'h000100, 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 40 && !done; i++) step();
        check_done("overflow");
        step();
        chk("overflow/hold", time_bcd, BCD_MAX);

        start = 1'b1;
        step();
        start = 1'b0;
        chk1("restart/ovf_cleared", overflow, 1'b0);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk ("midrst/time",    time_bcd,   24'h0);
        chk ("midrst/best",    best_bcd,   24'h0);
        chk1("midrst/valid",   best_valid, 1'b0);
        chk1("midrst/running", running,    1'b0);
        chk1("midrst/done",    done,       1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
